// File: rtl/mix_pkg.sv
// rtl/mix_pkg.sv - shared frame-state type and mode constants for mix_pipe
package mix_pkg;

  typedef enum logic {
    MIX_IDLE = 1'b0,
    MIX_OPEN = 1'b1
  } mix_state_t;

  localparam logic MIX_PASS  = 1'b0;
  localparam logic MIX_ACCUM = 1'b1;

endpackage

// File: rtl/mix_stage.sv
// rtl/mix_stage.sv - one elastic valid/ready register stage
// Accepts a new word whenever empty or when its current word leaves in the same cycle.
module mix_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign in_ready  = !r_valid || out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  // Data only changes on a load, so a stalled word stays stable at the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/mix_pipe.sv
// rtl/mix_pipe.sv - lane-wise XOR combiner with frame accumulation and elastic output pipe
// Parity is formed next to the result at stage 0 and carried down the pipe with it.
module mix_pipe
  import mix_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   in_mode,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_q,
  output logic [LANES-1:0]       out_parity,
  output logic                   out_err
);

  localparam int DW = LANES * WIDTH;
  localparam int SW = DW + LANES + 1;

  mix_state_t       r_state;
  logic [DW-1:0]    r_acc;

  logic [DW-1:0]    w_mix;
  logic [LANES-1:0] w_par;
  logic             w_emit;
  logic             w_err;
  logic             w_accept;
  logic [DEPTH:0]   w_valid;
  logic [SW-1:0]    w_data [0:DEPTH];

  // r_acc is zero while IDLE, so one expression covers every emitting case.
  assign w_mix    = r_acc ^ in_a ^ in_b;
  assign w_emit   = !((in_mode == MIX_ACCUM) && !in_last);
  assign w_err    = (in_mode == MIX_PASS) && (r_state == MIX_OPEN);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_par = '0;
    for (int i = 0; i < LANES; i++) begin
      w_par[i] = ^w_mix[i*WIDTH +: WIDTH];
    end
  end

  assign w_valid[0] = in_valid && w_emit;
  assign w_data[0]  = {w_err, w_par, w_mix};

  // Each stage keeps its own ready wire so the backward chain is not one self-dependent vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic w_in_ready;
    logic w_out_ready;

    if (k == DEPTH - 1) begin : g_last
      assign w_out_ready = out_ready;
    end else begin : g_mid
      assign w_out_ready = g_stage[k+1].w_in_ready;
    end

    mix_stage #(
      .W(SW)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .in_valid (w_valid[k]),
      .in_ready (w_in_ready),
      .in_data  (w_data[k]),
      .out_valid(w_valid[k+1]),
      .out_ready(w_out_ready),
      .out_data (w_data[k+1])
    );
  end

  assign in_ready  = g_stage[0].w_in_ready;
  assign out_valid = w_valid[DEPTH];
  assign {out_err, out_parity, out_q} = w_data[DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_state <= MIX_IDLE;
    end else if (w_accept) begin
      if (!w_emit) begin
        r_acc   <= w_mix;
        r_state <= MIX_OPEN;
      end else begin
        r_acc   <= '0;
        r_state <= MIX_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mix_pipe.sv
// tb/tb_mix_pipe.sv - self-checking bench for mix_pipe
module tb_mix_pipe;

  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int DEPTH = 2;
  localparam int DW    = LANES * WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_mode;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_q;
  logic [LANES-1:0] out_parity;
  logic          out_err;

  always #5 clk = ~clk;

  mix_pipe #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_parity(out_parity),
    .out_err   (out_err)
  );

  typedef struct {
    logic [DW-1:0]    q;
    logic [LANES-1:0] par;
    logic             err;
  } res_t;

  typedef struct {
    logic             mode;
    logic             last;
    logic [DW-1:0]    a;
    logic [DW-1:0]    b;
    logic             emit;
    logic [DW-1:0]    q;
    logic [LANES-1:0] par;
    logic             err;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  res_t exp_q[$];
  res_t mon_e;
  bit   use_model = 1'b0;
  bit   tbl_emit  = 1'b0;
  res_t tbl_exp;
  logic [DW-1:0] m_acc = '0;
  bit   m_open = 1'b0;
  bit   prev_stall = 1'b0;
  logic [DW+LANES:0] prev_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [LANES-1:0] lane_parity(input logic [DW-1:0] v);
    logic [LANES-1:0] p;
    for (int i = 0; i < LANES; i++) p[i] = ($countones(v[i*WIDTH +: WIDTH]) % 2) == 1;
    return p;
  endfunction

  // Frame rules: ACCUM without last folds into the running value; anything else
  // emits running^a^b, flagged when a PASS beat cuts an open frame.
  task automatic model_beat(input logic m, input logic l, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] v;
    v = m_acc ^ a ^ b;
    if (m && !l) begin
      m_acc  = v;
      m_open = 1'b1;
    end else begin
      exp_q.push_back('{q: v, par: lane_parity(v), err: (!m && m_open)});
      m_acc  = '0;
      m_open = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_acc      = '0;
      m_open     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", {out_err, out_parity, out_q}, prev_out);
      end
      check("in_ready", in_ready, !((exp_q.size() == DEPTH) && !out_ready));
      if (exp_q.size() == 0) check("idle_valid", out_valid, 1'b0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got %0h expected nothing", out_q);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_q", out_q, mon_e.q);
          check("out_parity", out_parity, mon_e.par);
          check("out_err", out_err, mon_e.err);
        end
      end
      if (in_valid && in_ready) begin
        if (use_model) model_beat(in_mode, in_last, in_a, in_b);
        else if (tbl_emit) exp_q.push_back(tbl_exp);
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_err, out_parity, out_q};
    end
  end

  task automatic send(input logic m, input logic l, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    in_mode = m; in_last = l; in_a = a; in_b = b; in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", (exp_q.size() == 0) && !out_valid, 1'b1);
  endtask

  vec_t vecs[10];
  int   accepted;
  int   cyc;
  bit   got;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_q", out_q, '0);
    check("rst_out_parity", out_parity, '0);
    check("rst_out_err", out_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // mode, last, a, b, emit, q, parity, err
    vecs[0] = '{1'b0, 1'b0, 32'h01020304, 32'h01010101, 1'b1, 32'h00030205, 4'b0010, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFE, 4'b0001, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h11111111, 32'h00000000, 1'b0, 32'h0,        4'b0000, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h22222222, 32'h00000000, 1'b0, 32'h0,        4'b0000, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h40404040, 32'h04040404, 1'b1, 32'h77777777, 4'b0000, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h000000FF, 32'h00000000, 1'b0, 32'h0,        4'b0000, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h0000FF00, 32'h00000000, 1'b1, 32'h0000FFFF, 4'b0000, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h12345678, 32'h00000000, 1'b1, 32'h12345678, 4'b0100, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 32'hFFFFFFFF, 4'b0000, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 32'h80000001, 32'h00000000, 1'b1, 32'h80000001, 4'b1001, 1'b0};

    use_model = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tbl_emit = vecs[i].emit;
      tbl_exp  = '{q: vecs[i].q, par: vecs[i].par, err: vecs[i].err};
      send(vecs[i].mode, vecs[i].last, vecs[i].a, vecs[i].b);
    end
    tbl_emit = 1'b0;
    drain();
    use_model = 1'b1;

    // Latency: accepted at edge N, visible after edge N+DEPTH-1.
    in_mode = 1'b0; in_last = 1'b0; in_a = 32'h01020304; in_b = 32'h01010101; in_valid = 1'b1;
    @(negedge clk);
    check("lat_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_early", out_valid, 1'b0);
    @(negedge clk);
    check("lat_on", out_valid, 1'b1);
    check("lat_q", out_q, 32'h00030205);
    @(posedge clk); #1;
    drain();

    // Throughput: one result per cycle once the pipe has filled.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_mode = 1'b0; in_a = $urandom; in_b = $urandom;
      @(negedge clk);
      if (i >= DEPTH) check("thru_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    drain();

    // Back-pressure: pipe fills after DEPTH accepts, absorbed beats blocked too.
    out_ready = 1'b0;
    accepted  = 0;
    in_mode = 1'b0; in_last = 1'b0; in_a = $urandom; in_b = $urandom; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk); #1;
      if (in_ready) begin in_a = $urandom; in_b = $urandom; end
    end
    check("bp_accepts", accepted, DEPTH);
    in_mode = 1'b1; in_last = 1'b0;
    @(negedge clk);
    check("bp_accum_block", in_ready, 1'b0);
    @(posedge clk); #1;
    in_mode = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = $urandom; in_b = $urandom;
      @(posedge clk); #1;
    end
    drain();

    // Reset mid-frame with a stalled beat in flight.
    out_ready = 1'b0;
    send(1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
    send(1'b1, 1'b0, 32'h11111111, 32'h0);
    send(1'b1, 1'b0, 32'h22222222, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_q", out_q, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_quiet", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    send(1'b0, 1'b0, 32'h0F0F0F0F, 32'hFF00FF00);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    check("post_rst_valid", got, 1'b1);
    if (got) begin
      check("post_rst_q", out_q, 32'hF00FF00F);
      check("post_rst_err", out_err, 1'b0);
    end
    @(posedge clk); #1;
    drain();

    // Random valid/ready, mixed modes, against the frame model.
    accepted = 0;
    cyc      = 0;
    while (accepted < 10000 && cyc < 60000) begin
      in_valid  = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 6;
      in_mode   = 1'($urandom);
      in_last   = ($urandom % 4) == 0;
      in_a      = $urandom;
      in_b      = $urandom;
      @(negedge clk);
      if (in_valid && in_ready) accepted++;
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_accepted", accepted, 10000);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
